// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multicycle control unit: state enum,
// opcode constants, ALU / mux select codes and the decode dispatch helper.
package mctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET  = 5'd0,
    S_FETCH  = 5'd1,
    S_DECODE = 5'd2,
    S_EXEC_R = 5'd3,
    S_EXEC_I = 5'd4,
    S_WB_ALU = 5'd5,
    S_ADDR   = 5'd6,
    S_MEM_RD = 5'd7,
    S_WB_MEM = 5'd8,
    S_MEM_WR = 5'd9,
    S_BRANCH = 5'd10,
    S_WB_LUI = 5'd11,
    S_TRAP   = 5'd12
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_LOAD = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_A     = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_IMMB = 2'd3;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_IMMU   = 2'd2;

  // Anything not explicitly recognised lands in S_TRAP.
  function automatic state_t decodeTarget(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic [6:0] funct7,
                                          input logic [2:0] lsFunct3);
    state_t tgt;
    tgt = S_TRAP;
    case (opcode)
      OP_R:      if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000))
                   tgt = S_EXEC_R;
      OP_IMM:    if (funct3 == 3'b000) tgt = S_EXEC_I;
      OP_LOAD:   if (funct3 == lsFunct3) tgt = S_ADDR;
      OP_STORE:  if (funct3 == lsFunct3) tgt = S_ADDR;
      OP_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) tgt = S_BRANCH;
      OP_LUI:    tgt = S_WB_LUI;
      default:   tgt = S_TRAP;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath bundle: IR/zero flag in, enables and selects out.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_fsm_if #(parameter int ALUOP_W = 3);
  logic [31:0]        instr;
  logic               alu_zero;
  logic               pc_write;
  logic               pc_write_cond;
  logic               pc_src;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mdr_load;
  logic               reg_a_load;
  logic               reg_b_load;
  logic               alu_out_load;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               reg_write;
  logic [1:0]         wb_sel;
  logic               illegal_instr;
  logic [4:0]         state_out;

  modport master (
    input  instr, alu_zero,
    output pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
           mdr_load, reg_a_load, reg_b_load, alu_out_load, alu_src_a, alu_src_b,
           alu_op, reg_write, wb_sel, illegal_instr, state_out
  );

  modport slave (
    output instr, alu_zero,
    input  pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
           mdr_load, reg_a_load, reg_b_load, alu_out_load, alu_src_a, alu_src_b,
           alu_op, reg_write, wb_sel, illegal_instr, state_out
  );
endinterface

// File: rtl/mctrl_wait_cnt.sv
// Memory wait counter: last flags the final cycle of a MEM_LAT-long access.
module mctrl_wait_cnt #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);
  localparam int CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + CW'(1);
  end

  assign last = (cnt == CW'(MEM_LAT - 1));
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM for the RV64I-subset datapath with memory wait states.
// Define MCTRL_INSTRET_EN to add the 64-bit retired-instruction counter port.
module multicycle_ctrl_fsm
  import mctrl_pkg::*;
#(
  parameter int         MEM_LAT   = 1,
  parameter logic [2:0] LS_FUNCT3 = 3'b011,
  parameter int         ALUOP_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_fsm_if.master bus
`ifdef MCTRL_INSTRET_EN
  ,
  output logic [63:0]           instret
`endif
);
  state_t state, nextState;
  logic   cntLast, cntClear, cntEnable;
  logic   unusedInstr;

  assign unusedInstr = ^{bus.instr[24:15], bus.instr[11:7]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RESET;
    else     state <= nextState;
  end

  // Any state change restarts the count, which covers every entry into a wait state.
  assign cntClear  = (nextState != state);
  assign cntEnable = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  mctrl_wait_cnt #(.MEM_LAT(MEM_LAT)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clear  (cntClear),
    .enable (cntEnable),
    .last   (cntLast)
  );

  assign bus.state_out = state;

  always_comb begin
    nextState         = state;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mdr_load      = 1'b0;
    bus.reg_a_load    = 1'b0;
    bus.reg_b_load    = 1'b0;
    bus.alu_out_load  = 1'b0;
    bus.alu_src_a     = SRCA_PC;
    bus.alu_src_b     = SRCB_B;
    bus.alu_op        = ALUOP_W'(ALU_LOAD);
    bus.reg_write     = 1'b0;
    bus.wb_sel        = WB_ALUOUT;
    bus.illegal_instr = 1'b0;
    case (state)
      S_RESET: nextState = S_FETCH;
      S_FETCH: begin
        bus.mem_read = 1'b1;
        if (cntLast) begin
          bus.ir_write  = 1'b1;
          bus.pc_write  = 1'b1;
          bus.alu_src_a = SRCA_PC;
          bus.alu_src_b = SRCB_FOUR;
          bus.alu_op    = ALUOP_W'(ALU_ADD);
          nextState     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target while A/B are loaded.
        bus.reg_a_load   = 1'b1;
        bus.reg_b_load   = 1'b1;
        bus.alu_out_load = 1'b1;
        bus.alu_src_a    = SRCA_OLDPC;
        bus.alu_src_b    = SRCB_IMMB;
        bus.alu_op       = ALUOP_W'(ALU_ADD);
        nextState = decodeTarget(bus.instr[6:0], bus.instr[14:12], bus.instr[31:25], LS_FUNCT3);
      end
      S_EXEC_R: begin
        bus.alu_src_a    = SRCA_A;
        bus.alu_src_b    = SRCB_B;
        bus.alu_op       = bus.instr[30] ? ALUOP_W'(ALU_SUB) : ALUOP_W'(ALU_ADD);
        bus.alu_out_load = 1'b1;
        nextState        = S_WB_ALU;
      end
      S_EXEC_I, S_ADDR: begin
        bus.alu_src_a    = SRCA_A;
        bus.alu_src_b    = SRCB_IMM;
        bus.alu_op       = ALUOP_W'(ALU_ADD);
        bus.alu_out_load = 1'b1;
        if (state == S_EXEC_I)                nextState = S_WB_ALU;
        else if (bus.instr[6:0] == OP_STORE)  nextState = S_MEM_WR;
        else                                  nextState = S_MEM_RD;
      end
      S_WB_ALU: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = WB_ALUOUT;
        nextState     = S_FETCH;
      end
      S_MEM_RD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
        if (cntLast) begin
          bus.mdr_load = 1'b1;
          nextState    = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = WB_MDR;
        nextState     = S_FETCH;
      end
      S_MEM_WR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        if (cntLast) nextState = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a     = SRCA_A;
        bus.alu_src_b     = SRCB_B;
        bus.alu_op        = ALUOP_W'(ALU_SUB);
        bus.pc_src        = 1'b1;
        bus.pc_write_cond = bus.instr[12] ? ~bus.alu_zero : bus.alu_zero;
        nextState         = S_FETCH;
      end
      S_WB_LUI: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = WB_IMMU;
        nextState     = S_FETCH;
      end
      S_TRAP:  bus.illegal_instr = 1'b1;
      default: nextState = S_RESET;
    endcase
  end

`ifdef MCTRL_INSTRET_EN
  logic retireState;
  assign retireState = (state == S_WB_ALU) || (state == S_WB_MEM) || (state == S_MEM_WR) ||
                       (state == S_BRANCH) || (state == S_WB_LUI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      instret <= '0;
    else if (retireState && nextState == S_FETCH) instret <= instret + 64'd1;
  end
`endif
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: two instances (MEM_LAT=1 and MEM_LAT=3)
// driven with directed instructions; per-cycle expected control words are queued.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic [4:0] st;
    logic       pcw, pcwc, pcsrc, iord, mrd, mwr, irw, mdr, ra, rb, aol;
    logic [1:0] sa, sb;
    logic [2:0] op;
    logic       rw;
    logic [1:0] wb;
    logic       ill;
  } ctl_t;

  logic clk = 1'b0;
  logic rst1, rst3;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [26:0] exp_q1[$];
  logic [26:0] exp_q3[$];
  logic [26:0] e1, e3;
  ctl_t        obs1, obs3;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.ALUOP_W(3)) bus1 ();
  multicycle_ctrl_fsm_if #(.ALUOP_W(3)) bus3 ();

`ifdef MCTRL_INSTRET_EN
  logic [63:0] instret1, instret3;
`endif

  multicycle_ctrl_fsm #(.MEM_LAT(1), .LS_FUNCT3(3'b011), .ALUOP_W(3)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
`ifdef MCTRL_INSTRET_EN
    ,
    .instret (instret1)
`endif
  );

  multicycle_ctrl_fsm #(.MEM_LAT(3), .LS_FUNCT3(3'b011), .ALUOP_W(3)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
`ifdef MCTRL_INSTRET_EN
    ,
    .instret (instret3)
`endif
  );

  assign obs1 = {bus1.state_out, bus1.pc_write, bus1.pc_write_cond, bus1.pc_src, bus1.iord,
                 bus1.mem_read, bus1.mem_write, bus1.ir_write, bus1.mdr_load, bus1.reg_a_load,
                 bus1.reg_b_load, bus1.alu_out_load, bus1.alu_src_a, bus1.alu_src_b,
                 bus1.alu_op, bus1.reg_write, bus1.wb_sel, bus1.illegal_instr};
  assign obs3 = {bus3.state_out, bus3.pc_write, bus3.pc_write_cond, bus3.pc_src, bus3.iord,
                 bus3.mem_read, bus3.mem_write, bus3.ir_write, bus3.mdr_load, bus3.reg_a_load,
                 bus3.reg_b_load, bus3.alu_out_load, bus3.alu_src_a, bus3.alu_src_b,
                 bus3.alu_op, bus3.reg_write, bus3.wb_sel, bus3.illegal_instr};

  // ---------------- expected control words, one per state ----------------
  function automatic ctl_t reset_v();
    ctl_t c; c = '0; return c;
  endfunction
  function automatic ctl_t fetch_v(input bit last);
    ctl_t c; c = '0; c.st = 5'd1; c.mrd = 1'b1;
    if (last) begin c.irw = 1'b1; c.pcw = 1'b1; c.sb = 2'd1; c.op = 3'b001; end
    return c;
  endfunction
  function automatic ctl_t decode_v();
    ctl_t c; c = '0; c.st = 5'd2; c.ra = 1'b1; c.rb = 1'b1; c.aol = 1'b1;
    c.sa = 2'd2; c.sb = 2'd3; c.op = 3'b001; return c;
  endfunction
  function automatic ctl_t execr_v(input bit sub);
    ctl_t c; c = '0; c.st = 5'd3; c.sa = 2'd1; c.sb = 2'd0; c.aol = 1'b1;
    c.op = sub ? 3'b010 : 3'b001; return c;
  endfunction
  function automatic ctl_t execi_v();
    ctl_t c; c = '0; c.st = 5'd4; c.sa = 2'd1; c.sb = 2'd2; c.op = 3'b001; c.aol = 1'b1; return c;
  endfunction
  function automatic ctl_t wbalu_v();
    ctl_t c; c = '0; c.st = 5'd5; c.rw = 1'b1; c.wb = 2'd0; return c;
  endfunction
  function automatic ctl_t addr_v();
    ctl_t c; c = '0; c.st = 5'd6; c.sa = 2'd1; c.sb = 2'd2; c.op = 3'b001; c.aol = 1'b1; return c;
  endfunction
  function automatic ctl_t memrd_v(input bit last);
    ctl_t c; c = '0; c.st = 5'd7; c.iord = 1'b1; c.mrd = 1'b1; c.mdr = last; return c;
  endfunction
  function automatic ctl_t wbmem_v();
    ctl_t c; c = '0; c.st = 5'd8; c.rw = 1'b1; c.wb = 2'd1; return c;
  endfunction
  function automatic ctl_t memwr_v();
    ctl_t c; c = '0; c.st = 5'd9; c.iord = 1'b1; c.mwr = 1'b1; return c;
  endfunction
  function automatic ctl_t branch_v(input bit take);
    ctl_t c; c = '0; c.st = 5'd10; c.sa = 2'd1; c.sb = 2'd0; c.op = 3'b010;
    c.pcsrc = 1'b1; c.pcwc = take; return c;
  endfunction
  function automatic ctl_t lui_v();
    ctl_t c; c = '0; c.st = 5'd11; c.rw = 1'b1; c.wb = 2'd2; return c;
  endfunction
  function automatic ctl_t trap_v();
    ctl_t c; c = '0; c.st = 5'd12; c.ill = 1'b1; return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input ctl_t c);
    if (d == 1) exp_q1.push_back(c);
    else        exp_q3.push_back(c);
  endtask

  task automatic set_instr(input int d, input logic [31:0] ins, input logic z);
    if (d == 1) begin bus1.instr = ins; bus1.alu_zero = z; end
    else        begin bus3.instr = ins; bus3.alu_zero = z; end
  endtask

  task automatic fetch_seq(input int d, input int lat);
    for (int i = 0; i < lat; i++) push(d, fetch_v(i == lat - 1));
  endtask

  task automatic run_r(input int d, input int lat, input logic [31:0] ins, input bit sub);
    set_instr(d, ins, 1'b0);
    fetch_seq(d, lat); push(d, decode_v()); push(d, execr_v(sub)); push(d, wbalu_v());
    tick(lat + 3);
  endtask

  task automatic run_i(input int d, input int lat, input logic [31:0] ins);
    set_instr(d, ins, 1'b0);
    fetch_seq(d, lat); push(d, decode_v()); push(d, execi_v()); push(d, wbalu_v());
    tick(lat + 3);
  endtask

  task automatic run_ld(input int d, input int lat, input logic [31:0] ins);
    set_instr(d, ins, 1'b0);
    fetch_seq(d, lat); push(d, decode_v()); push(d, addr_v());
    for (int i = 0; i < lat; i++) push(d, memrd_v(i == lat - 1));
    push(d, wbmem_v());
    tick(2 * lat + 3);
  endtask

  task automatic run_sd(input int d, input int lat, input logic [31:0] ins);
    set_instr(d, ins, 1'b0);
    fetch_seq(d, lat); push(d, decode_v()); push(d, addr_v());
    for (int i = 0; i < lat; i++) push(d, memwr_v());
    tick(2 * lat + 2);
  endtask

  task automatic run_br(input int d, input int lat, input logic [31:0] ins, input logic z,
                        input bit take);
    set_instr(d, ins, z);
    fetch_seq(d, lat); push(d, decode_v()); push(d, branch_v(take));
    tick(lat + 2);
  endtask

  task automatic run_lui(input int d, input int lat, input logic [31:0] ins);
    set_instr(d, ins, 1'b0);
    fetch_seq(d, lat); push(d, decode_v()); push(d, lui_v());
    tick(lat + 2);
  endtask

  task automatic run_trap(input int d, input int lat, input logic [31:0] ins, input int n);
    set_instr(d, ins, 1'b0);
    fetch_seq(d, lat); push(d, decode_v());
    for (int i = 0; i < n; i++) push(d, trap_v());
    tick(lat + 1 + n);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q1.size() > 0) begin
      e1 = exp_q1.pop_front();
      n_cmp++;
      if (obs1 !== e1) begin
        n_bad++;
        $display("FAIL dut1_ctl @%0t: actual %h (state %0d) required %h (state %0d)",
                 $time, obs1, obs1.st, e1, e1[26:22]);
      end
    end
    if (exp_q3.size() > 0) begin
      e3 = exp_q3.pop_front();
      n_cmp++;
      if (obs3 !== e3) begin
        n_bad++;
        $display("FAIL dut3_ctl @%0t: actual %h (state %0d) required %h (state %0d)",
                 $time, obs3, obs3.st, e3, e3[26:22]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst1 = 1'b1;
    rst3 = 1'b1;
    set_instr(1, 32'h0, 1'b0);
    set_instr(3, 32'h0, 1'b0);
    @(posedge clk); #1;
    push(1, reset_v());
    push(3, reset_v());
    rst1 = 1'b0;
    tick(1);

    // MEM_LAT = 1 instance
    run_r(1, 1, 32'h002081B3, 1'b0);            // add x3,x1,x2
    run_r(1, 1, 32'h402081B3, 1'b1);            // sub x3,x1,x2
    run_br(1, 1, 32'h00208463, 1'b1, 1'b1);     // beq, zero -> taken
`ifdef MCTRL_INSTRET_EN
    chk("instret_after_3", instret1, 64'd3);
`endif
    // ld interrupted by reset while in MEM_RD
    set_instr(1, 32'h0080B283, 1'b0);
    fetch_seq(1, 1); push(1, decode_v()); push(1, addr_v());
    tick(3);
    chk("pre_rst_state_memrd", {59'd0, bus1.state_out}, 64'd7);
    rst1 = 1'b1;
    #1;
    chk("async_rst_state", {59'd0, bus1.state_out}, 64'd0);
    chk("async_rst_mdr", {63'd0, bus1.mdr_load}, 64'd0);
    push(1, reset_v());
    tick(1);
    rst1 = 1'b0;
    push(1, reset_v());
    tick(1);
`ifdef MCTRL_INSTRET_EN
    chk("instret_after_rst", instret1, 64'd0);
`endif
    run_r(1, 1, 32'h002081B3, 1'b0);            // add
    run_sd(1, 1, 32'h0020B823);                 // sd x2,16(x1)
    run_i(1, 1, 32'h00508093);                  // addi x1,x1,5
    run_lui(1, 1, 32'h123450B7);                // lui x1,0x12345
    run_br(1, 1, 32'h00209463, 1'b1, 1'b0);     // bne, zero -> not taken
    run_trap(1, 1, 32'h0000007F, 10);           // illegal opcode
`ifdef MCTRL_INSTRET_EN
    chk("instret_in_trap", instret1, 64'd5);
`endif

    // MEM_LAT = 3 instance
    rst3 = 1'b0;
    push(3, reset_v());
    tick(1);
    run_ld(3, 3, 32'h0080B283);                 // ld x5,8(x1): 9 cycles
    run_sd(3, 3, 32'h0020B823);                 // sd: 8 cycles
    run_br(3, 3, 32'h00208463, 1'b0, 1'b0);     // beq, nonzero -> not taken
    run_br(3, 3, 32'h00209463, 1'b0, 1'b1);     // bne, nonzero -> taken
    run_r(3, 3, 32'h002081B3, 1'b0);            // add: 6 cycles
`ifdef MCTRL_INSTRET_EN
    chk("instret3_after_5", instret3, 64'd5);
`endif

    guard = 0;
    while ((exp_q1.size() != 0 || exp_q3.size() != 0) && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    chk("queues_drained", 64'(exp_q1.size() + exp_q3.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Parametrised multicycle control unit for the RV64I-subset datapath (PC, IR, A/B, ALUOut, MDR registers, shared memory port).
- Decodes add, sub, addi, load, store, beq, bne and lui.
- Inserts configurable memory wait cycles and traps illegal encodings.
- Drives all datapath enables and selects; replaces the previous fixed-latency controller.

Parameters:
- MEM_LAT, 1, memory access latency in cycles (≥1); data valid on the last wait cycle.
- LS_FUNCT3, 3'b011, funct3 accepted for load/store (ld/sd).
- ALUOP_W, 3, ALU operation code width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- instr  in  32  IR contents
- alu_zero  in  1  ALU zero flag (combinational, current cycle)
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load, asserted only when branch taken
- pc_src  out  1  0 = ALU result, 1 = ALUOut
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- mdr_load  out  1  MDR load
- reg_a_load  out  1  A load
- reg_b_load  out  1  B load
- alu_out_load  out  1  ALUOut load
- alu_src_a  out  2  0 = PC, 1 = A, 2 = old PC
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = imm_I/S, 3 = imm_B
- alu_op  out  ALUOP_W  ALU operation (package codes)
- reg_write  out  1  register file write
- wb_sel  out  2  0 = ALUOut, 1 = MDR, 2 = imm_U
- illegal_instr  out  1  sticky trap flag
- state_out  out  5  current state encoding (debug)

Behaviour:
- Reset: rst asynchronous, active-high; clock clk.
  - Asserting rst at any time forces RESET and clears the wait counter.
  - All outputs are 0 in RESET, state_out = 0.
  - RESET → FETCH unconditionally on the next edge.
- Outputs: combinational from state, wait counter, instr and alu_zero. Unlisted outputs are 0 in every state.
- Wait counter cnt:
  - Width $clog2(MEM_LAT+1).
  - Cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle in those states.
  - "last" means cnt == MEM_LAT-1.
- FETCH:
  - Every cycle: mem_read=1, iord=0.
  - On last: ir_write=1, pc_write=1, pc_src=0, alu_src_a=0, alu_src_b=1, alu_op=ADD; then → DECODE. Otherwise stay.
- DECODE:
  - reg_a_load=1, reg_b_load=1, alu_out_load=1, alu_src_a=2, alu_src_b=3, alu_op=ADD (branch target).
  - Dispatch on instr[6:0], funct3 and funct7:
    - 0110011, f3=000, f7=0000000 → EXEC_R (ADD).
    - 0110011, f3=000, f7=0100000 → EXEC_R (SUB).
    - 0010011, f3=000 → EXEC_I.
    - 0000011, f3=LS_FUNCT3 → ADDR.
    - 0100011, f3=LS_FUNCT3 → ADDR.
    - 1100011, f3=000 or 001 → BRANCH.
    - 0110111 → WB_LUI.
    - Anything else → TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=ADD/SUB from funct7, alu_out_load=1 → WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=ADD, alu_out_load=1 → WB_ALU.
- WB_ALU: reg_write=1, wb_sel=0 → FETCH.
- ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD, alu_out_load=1 → MEM_RD if load, MEM_WR if store.
- MEM_RD:
  - Every cycle: iord=1, mem_read=1.
  - On last: mdr_load=1; then → WB_MEM.
- WB_MEM: reg_write=1, wb_sel=1 → FETCH.
- MEM_WR: iord=1, mem_write=1 every cycle; on last → FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1.
  - pc_write_cond = alu_zero for f3=000 (beq), ~alu_zero for f3=001 (bne).
  - → FETCH.
- WB_LUI: reg_write=1, wb_sel=2 → FETCH.
- TRAP: illegal_instr=1; stays until rst. No memory, PC or register activity.
- MEM_LAT=1: each memory state lasts exactly one cycle.
- Instruction latencies (cycles, including fetch):
  - R/I: MEM_LAT+3
  - load: 2·MEM_LAT+3
  - store: 2·MEM_LAT+2
  - branch, lui: MEM_LAT+2

Optional Feature:
- Macro MCTRL_INSTRET_EN.
- When defined:
  - Adds output instret [63:0], reset to 0.
  - Increments by 1 on every transition into FETCH from WB_ALU, WB_MEM, MEM_WR, BRANCH or WB_LUI.
  - Wraps at 2^64-1 → 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mctrl_pkg holds:
  - state enum (5-bit, RESET=0);
  - opcode constants;
  - ALU codes LOAD=3'b000, ADD=3'b001, SUB=3'b010;
  - alu_src_b and wb_sel encodings.
- Sub-module mctrl_wait_cnt, parametrised by MEM_LAT:
  - inputs clear, enable;
  - output last.

Test Plan:
- MEM_LAT=1; rst mid-MEM_RD → state_out=0 asynchronously, no mdr_load; next edge FETCH with mem_read=1.
- add x3,x1,x2 (0x002081B3) → FETCH, DECODE, EXEC_R alu_op=001, WB_ALU reg_write=1 wb_sel=0, back to FETCH; 4 cycles.
- sub (0x402081B3) → EXEC_R alu_op=010; lui (0x123450B7) → WB_LUI wb_sel=2.
- MEM_LAT=3; ld (f3=011) → mem_read held 3 cycles, mdr_load only on the 3rd, reg_write in WB_MEM; 9 cycles total.
- beq with alu_zero=1 → pc_write_cond=1 pc_src=1; bne with alu_zero=1 → pc_write_cond=0.
- opcode 0x7F → TRAP, illegal_instr=1 held 10 cycles; instret (with MCTRL_INSTRET_EN) unchanged, equals prior retired count (e.g. 3 after add, sub, beq).
